// File: rtl/spi_master_ctrl_if.sv
// Request/response and serial-link bundle for the SPI master controller.
// Latency: none, wires only; the controller decides all timing.
// Backpressure: req_valid/req_ready; the response side has no backpressure.
// Optional feature macro: SPIM_ABORT_EN adds abort (in) and rsp_err (out).
interface spi_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
`ifdef SPIM_ABORT_EN
    logic       abort;
    logic       rsp_err;
`endif

`ifdef SPIM_ABORT_EN
    // Controller side: owns the request handshake, response strobe and serial outputs.
    modport master (
        input  req_valid, req_cmd, req_data, MISO, abort,
        output req_ready, rsp_valid, rsp_data, SS_n, MOSI, rsp_err
    );

    // System side plus slave wrapper: drives requests and MISO, observes the rest.
    modport slave (
        output req_valid, req_cmd, req_data, MISO, abort,
        input  req_ready, rsp_valid, rsp_data, SS_n, MOSI, rsp_err
    );
`else
    // Controller side: owns the request handshake, response strobe and serial outputs.
    modport master (
        input  req_valid, req_cmd, req_data, MISO,
        output req_ready, rsp_valid, rsp_data, SS_n, MOSI
    );

    // System side plus slave wrapper: drives requests and MISO, observes the rest.
    modport slave (
        output req_valid, req_cmd, req_data, MISO,
        input  req_ready, rsp_valid, rsp_data, SS_n, MOSI
    );
`endif
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises one {cmd,data} RAM command frame per request, captures the read byte for cmd 11.
// Latency: SS_n low 12 cycles (20+RD_WAIT for read-data), then a one-cycle response strobe in END.
// Backpressure: req_ready only in IDLE; requests while busy are neither taken nor stored. Macro: SPIM_ABORT_EN.
module spi_master_ctrl #(
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        SHIFT,
        WAIT,
        RECV,
        END
    } state_t;

    // Counter reload values: each timed state runs from its load value down to zero.
    localparam logic [3:0] CMD_LOAD   = 4'd1;
    localparam logic [3:0] SHIFT_LOAD = 4'd9;
    localparam logic [3:0] WAIT_LOAD  = 4'(RD_WAIT - 1);
    localparam logic [3:0] RECV_LOAD  = 4'd7;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [9:0] frame_q;
    logic [7:0] rx_q;
    logic [7:0] rsp_data_q;
    logic       accept;
    logic       abort_hit;
    logic       enter_end;
    logic       ss_n_c;
    logic       mosi_c;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign enter_end = (state_d == END) && (state_q != END);

`ifdef SPIM_ABORT_EN
    logic err_q;

    // Abort only matters while a frame is in flight; IDLE and END ignore it.
    assign abort_hit   = bus.abort && (state_q != IDLE) && (state_q != END);
    assign bus.rsp_err = (state_q == END) && err_q;

    // Remember whether the response about to be issued comes from an aborted frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (enter_end) begin
            err_q <= abort_hit;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    // State and shared down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter: reload on every state entry, count down while staying.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (accept) begin
                    state_d = CMD;
                    cnt_d   = CMD_LOAD;
                end
            end
            CMD: begin
                if (cnt_q == 4'd0) begin
                    state_d = SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == 4'd0) begin
                    if (frame_q[9:8] == 2'b11) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = END;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RECV;
                    cnt_d   = RECV_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECV: begin
                if (cnt_q == 4'd0) begin
                    state_d = END;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            END: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (abort_hit) begin
            state_d = END;
            cnt_d   = 4'd0;
        end
    end

    // Serial outputs are pure functions of state so reset releases SS_n without a clock.
    always_comb begin
        ss_n_c = 1'b1;
        mosi_c = 1'b0;
        case (state_q)
            CMD: begin
                ss_n_c = 1'b0;
                mosi_c = frame_q[9];
            end
            SHIFT: begin
                ss_n_c = 1'b0;
                mosi_c = frame_q[cnt_q];
            end
            WAIT, RECV: begin
                ss_n_c = 1'b0;
            end
            default: begin
                ss_n_c = 1'b1;
                mosi_c = 1'b0;
            end
        endcase
    end

    // Frame latch on accept, MISO capture MSB first, response byte loaded on the way into END.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= 10'd0;
            rx_q       <= 8'h00;
            rsp_data_q <= 8'h00;
        end else begin
            if (accept) begin
                frame_q <= {bus.req_cmd, bus.req_data};
            end
            if (state_q == RECV) begin
                rx_q <= {rx_q[6:0], bus.MISO};
            end
            if (enter_end) begin
                if (!abort_hit && (state_q == RECV)) begin
                    rsp_data_q <= {rx_q[6:0], bus.MISO};
                end else begin
                    rsp_data_q <= 8'h00;
                end
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == END);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.SS_n      = ss_n_c;
    assign bus.MOSI      = mosi_c;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: random command streams checked cycle by cycle against a frame-level model.
// Latency: not applicable.
// Backpressure: holds req_valid through busy frames to exercise request rejection.
module tb_spi_master_ctrl;
    localparam int RD_WAIT = 2;
    localparam int MAXC    = 800;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_master_ctrl_if bus();

    spi_master_ctrl #(.RD_WAIT(RD_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Byte the model says rsp_data must currently hold.
    logic [7:0] mdl_rd;

    // Transaction list consumed by build().
    int         q_gap[$];
    logic [1:0] q_cmd[$];
    logic [7:0] q_data[$];
    logic [7:0] q_miso[$];
    bit         q_hold[$];

    // Per-cycle drive and expectation tables, and captured observations.
    logic       d_valid[MAXC];
    logic [1:0] d_cmd[MAXC];
    logic [7:0] d_data[MAXC];
    logic       d_miso[MAXC];
    logic       e_ss[MAXC], e_mosi[MAXC], e_rv[MAXC], e_rdy[MAXC];
    logic [7:0] e_rd[MAXC];
    logic       o_ss[MAXC], o_mosi[MAXC], o_rv[MAXC], o_rdy[MAXC];
    logic [7:0] o_rd[MAXC];
    int         n_cyc;

    task automatic put(int c, logic v, logic [1:0] cm, logic [7:0] dt, logic ms,
                       logic ss, logic mo, logic rv, logic rdy);
        d_valid[c] = v;
        d_cmd[c]   = cm;
        d_data[c]  = dt;
        d_miso[c]  = ms;
        e_ss[c]    = ss;
        e_mosi[c]  = mo;
        e_rv[c]    = rv;
        e_rdy[c]   = rdy;
        e_rd[c]    = mdl_rd;
    endtask

    // Frame-level model: each request becomes IDLE-accept, a run of SS_n-low bits, one END cycle.
    task automatic build();
        int         c;
        int         nb;
        int         rs;
        logic [9:0] f;
        logic [7:0] mb;
        logic       bits[40];
        logic       ms;
        c = 0;
        for (int i = 0; i < q_cmd.size(); i++) begin
            f  = {q_cmd[i], q_data[i]};
            mb = q_miso[i];
            for (int g = 0; g < q_gap[i]; g++) begin
                put(c, 1'b0, 2'($urandom()), 8'($urandom()), 1'($urandom()), 1'b1, 1'b0, 1'b0, 1'b1);
                c++;
            end
            put(c, 1'b1, q_cmd[i], q_data[i], 1'($urandom()), 1'b1, 1'b0, 1'b0, 1'b1);
            c++;
            nb = 0;
            bits[nb++] = f[9];
            bits[nb++] = f[9];
            for (int b = 9; b >= 0; b--) bits[nb++] = f[b];
            rs = nb + RD_WAIT;
            if (q_cmd[i] == 2'b11) begin
                for (int b = 0; b < RD_WAIT + 8; b++) bits[nb++] = 1'b0;
            end
            for (int k = 0; k < nb; k++) begin
                ms = 1'($urandom());
                if (q_cmd[i] == 2'b11 && k >= rs) ms = mb[7 - (k - rs)];
                put(c, logic'(q_hold[i]), 2'($urandom()), 8'($urandom()), ms, 1'b0, bits[k], 1'b0, 1'b0);
                c++;
            end
            mdl_rd = (q_cmd[i] == 2'b11) ? mb : 8'h00;
            put(c, logic'(q_hold[i]), 2'($urandom()), 8'($urandom()), 1'($urandom()), 1'b1, 1'b0, 1'b1, 1'b0);
            c++;
        end
        for (int g = 0; g < 3; g++) begin
            put(c, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            c++;
        end
        n_cyc = c;
        q_gap.delete();
        q_cmd.delete();
        q_data.delete();
        q_miso.delete();
        q_hold.delete();
    endtask

    // Replay the drive table: sample outputs at each falling edge, then apply that cycle's inputs.
    task automatic play();
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            o_ss[c]  = bus.SS_n;
            o_mosi[c] = bus.MOSI;
            o_rv[c]  = bus.rsp_valid;
            o_rdy[c] = bus.req_ready;
            o_rd[c]  = bus.rsp_data;
            bus.req_valid = d_valid[c];
            bus.req_cmd   = d_cmd[c];
            bus.req_data  = d_data[c];
            bus.MISO      = d_miso[c];
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic add(int gap, logic [1:0] cm, logic [7:0] dt, logic [7:0] ms, bit hold);
        q_gap.push_back(gap);
        q_cmd.push_back(cm);
        q_data.push_back(dt);
        q_miso.push_back(ms);
        q_hold.push_back(hold);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_data  = 8'h00;
        bus.MISO      = 1'b0;
`ifdef SPIM_ABORT_EN
        bus.abort     = 1'b0;
`endif
        rst_n  = 1'b0;
        mdl_rd = 8'h00;
        #3;
        total++;
        if (bus.SS_n !== 1'b1) begin bad++; $display("FAIL reset_ss got=%b exp=1", bus.SS_n); end
        total++;
        if (bus.MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus.MOSI); end
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", bus.rsp_valid); end
        total++;
        if (bus.rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", bus.rsp_data); end
`ifdef SPIM_ABORT_EN
        total++;
        if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.rsp_err); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_addr();
        add(0, 2'b00, 8'hA5, 8'h00, 1'b0);
        build();
        play();
        for (int c = 0; c < n_cyc; c++) begin
            total++;
            if ({o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c]} !== {e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]}) begin
                bad++;
                $display("FAIL wr_addr cyc=%0d ss,mosi,rv,rdy/rd got=%b%b%b%b/%h exp=%b%b%b%b/%h", c,
                         o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c], e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        add(0, 2'b01, 8'h3C, 8'h00, 1'b1);
        add(0, 2'b10, 8'h07, 8'h00, 1'b1);
        build();
        play();
        for (int c = 0; c < n_cyc; c++) begin
            total++;
            if ({o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c]} !== {e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]}) begin
                bad++;
                $display("FAIL b2b cyc=%0d ss,mosi,rv,rdy/rd got=%b%b%b%b/%h exp=%b%b%b%b/%h", c,
                         o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c], e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            add($urandom_range(0, 2), 2'($urandom()), 8'($urandom()), 8'($urandom()), bit'($urandom()));
        end
        build();
        play();
        for (int c = 0; c < n_cyc; c++) begin
            total++;
            if ({o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c]} !== {e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]}) begin
                bad++;
                $display("FAIL random cyc=%0d ss,mosi,rv,rdy/rd got=%b%b%b%b/%h exp=%b%b%b%b/%h", c,
                         o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c], e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]);
            end
        end
    endtask

    task automatic test_read_data();
        add(1, 2'b11, 8'($urandom()), 8'hC3, 1'b0);
        build();
        play();
        for (int c = 0; c < n_cyc; c++) begin
            total++;
            if ({o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c]} !== {e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]}) begin
                bad++;
                $display("FAIL rd_data cyc=%0d ss,mosi,rv,rdy/rd got=%b%b%b%b/%h exp=%b%b%b%b/%h", c,
                         o_ss[c], o_mosi[c], o_rv[c], o_rdy[c], o_rd[c], e_ss[c], e_mosi[c], e_rv[c], e_rdy[c], e_rd[c]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] dt;
        logic [9:0] f;
        int         errs;
        dt = 8'($urandom());
        f  = {2'b00, dt};
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 2'b00;
        bus.req_data  = dt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if ({bus.SS_n, bus.MOSI} !== {1'b0, f[5]}) begin
            bad++;
            $display("FAIL mid_shift_bit5 ss,mosi got=%b%b exp=0%b", bus.SS_n, bus.MOSI, f[5]);
        end
        #2;
        rst_n  = 1'b0;
        mdl_rd = 8'h00;
        #1;
        total++;
        if ({bus.SS_n, bus.MOSI, bus.req_ready, bus.rsp_valid, bus.rsp_data} !== {4'b1010, 8'h00}) begin
            bad++;
            $display("FAIL async_reset ss,mosi,rdy,rv/rd got=%b%b%b%b/%h exp=1010/00",
                     bus.SS_n, bus.MOSI, bus.req_ready, bus.rsp_valid, bus.rsp_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        errs  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.SS_n !== 1'b1 || bus.req_ready !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL post_reset_quiet bad_cycles got=%0d exp=0", errs);
        end
    endtask

`ifdef SPIM_ABORT_EN
    task automatic test_abort();
        int k_ab;
        k_ab = 12 + RD_WAIT + 3;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 2'b11;
        bus.req_data  = 8'($urandom());
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < k_ab; k++) begin
            bus.MISO = 1'b1;
            @(negedge clk);
        end
        total++;
        if (bus.SS_n !== 1'b0) begin bad++; $display("FAIL abort_pre_ss got=%b exp=0", bus.SS_n); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        mdl_rd    = 8'h00;
        total++;
        if ({bus.SS_n, bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {3'b111, 8'h00}) begin
            bad++;
            $display("FAIL abort_rsp ss,rv,err/rd got=%b%b%b/%h exp=111/00",
                     bus.SS_n, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL abort_after rv,err,rdy got=%b%b%b exp=001", bus.rsp_valid, bus.rsp_err, bus.req_ready);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_addr();
        test_back_to_back();
        test_random();
        test_read_data();
        test_reset_mid_shift();
`ifdef SPIM_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
